arbiter_requester: RTL

//  Master-side end of the serial arbitration link: serialises bus requests onto arb_out, tracks
//  the grant on arb_in, frames communication start/end/abort, and gives the master datapath a

---
 rtl/arb_proto_pkg.sv | 26 ++
 rtl/arb_frame_tx.sv | 46 ++++
 rtl/arbiter_requester.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/arb_proto_pkg.sv
// Arbitration link protocol: frame codes, frame lengths and the requester state encoding.
package arb_proto_pkg;

    localparam int unsigned HDR_LEN   = 3;
    localparam int unsigned START_LEN = 3;
    localparam int unsigned NAK_LEN   = 3;
    localparam int unsigned END_LEN   = 2;

    localparam logic [2:0] HDR_CODE   = 3'b111;
    localparam logic [2:0] START_CODE = 3'b101;
    localparam logic [2:0] NAK_CODE   = 3'b110;
    localparam logic [1:0] END_CODE   = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_ID,
        ST_WAIT_GRANT,
        ST_SEND_START,
        ST_COM,
        ST_SEND_END,
        ST_SEND_NAK,
        ST_WAIT_REL
    } state_t;

endpackage

// File: rtl/arb_frame_tx.sv
// Serial frame shifter: loads a left-aligned code plus length and drives it MSB-first on arb_out.
module arb_frame_tx #(
    parameter int unsigned SH_W  = 3,
    parameter int unsigned LEN_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             abort,
    input  logic [SH_W-1:0]  data,
    input  logic [LEN_W-1:0] len,
    output logic             arb_out,
    output logic             last_bit_c
);

    logic [SH_W-1:0]  sh_q;
    logic [LEN_W-1:0] rem_q;
    logic             active_q;

    // The first bit appears on arb_out in the cycle right after load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q     <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
        end else if (abort) begin
            sh_q     <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            sh_q     <= data;
            rem_q    <= len - LEN_W'(1);
            active_q <= 1'b1;
        end else if (rem_q != '0) begin
            sh_q     <= sh_q << 1;
            rem_q    <= rem_q - LEN_W'(1);
        end else begin
            sh_q     <= '0;
            active_q <= 1'b0;
        end
    end

    assign arb_out    = sh_q[SH_W-1];
    assign last_bit_c = active_q && (rem_q == '0);

endmodule

// File: rtl/arbiter_requester.sv
// Master-side arbitration link endpoint: request/ID framing, grant tracking, comm start/end/abort.
module arbiter_requester
    import arb_proto_pkg::*;
#(
    parameter int unsigned ID_W     = 2,
    parameter int unsigned GRANT_TO = 64,
    parameter int unsigned REL_TO   = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req,
    input  logic [ID_W-1:0] master_id,
    input  logic            done,
    input  logic            arb_in,
    output logic            arb_out,
    output logic            bus_grant,
    output logic            busy,
    output logic            timeout,
    output logic            lost_grant
);

    localparam int unsigned SH_W    = (ID_W > HDR_LEN) ? ID_W : HDR_LEN;
    localparam int unsigned LEN_W   = $clog2(SH_W + 1);
    localparam int unsigned CNT_MAX = (GRANT_TO > REL_TO) ? GRANT_TO : REL_TO;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [ID_W-1:0]   id_q;
    logic              id_load_c;
    logic              tx_load_c, tx_abort_c, tx_last_c;
    logic [SH_W-1:0]   tx_data_c;
    logic [LEN_W-1:0]  tx_len_c;
    logic              timeout_c, lost_grant_c;

    arb_frame_tx #(
        .SH_W  (SH_W),
        .LEN_W (LEN_W)
    ) u_frame_tx (
        .clk        (clk),
        .rstn       (rstn),
        .load       (tx_load_c),
        .abort      (tx_abort_c),
        .data       (tx_data_c),
        .len        (tx_len_c),
        .arb_out    (arb_out),
        .last_bit_c (tx_last_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            id_q       <= '0;
            bus_grant  <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            lost_grant <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            if (id_load_c) begin
                id_q <= master_id;
            end
            bus_grant  <= (state_n == ST_COM);
            busy       <= (state_n != ST_IDLE);
            timeout    <= timeout_c;
            lost_grant <= lost_grant_c;
        end
    end

    // Counter is zero unless holding in a wait state, so every state entry clears it.
    always_comb begin
        state_n      = state_q;
        cnt_n        = '0;
        id_load_c    = 1'b0;
        tx_load_c    = 1'b0;
        tx_abort_c   = 1'b0;
        tx_data_c    = '0;
        tx_len_c     = '0;
        timeout_c    = 1'b0;
        lost_grant_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_n   = ST_SEND_HDR;
                    id_load_c = 1'b1;
                    tx_load_c = 1'b1;
                    tx_data_c = SH_W'(HDR_CODE) << (SH_W - HDR_LEN);
                    tx_len_c  = LEN_W'(HDR_LEN);
                end
            end
            ST_SEND_HDR: begin
                if (tx_last_c) begin
                    state_n   = ST_SEND_ID;
                    tx_load_c = 1'b1;
                    tx_data_c = SH_W'(id_q) << (SH_W - ID_W);
                    tx_len_c  = LEN_W'(ID_W);
                end
            end
            ST_SEND_ID: begin
                if (tx_last_c) begin
                    state_n = ST_WAIT_GRANT;
                end
            end
            ST_WAIT_GRANT: begin
                if (arb_in) begin
                    tx_load_c = 1'b1;
                    tx_len_c  = LEN_W'(START_LEN);
                    if (req) begin
                        state_n   = ST_SEND_START;
                        tx_data_c = SH_W'(START_CODE) << (SH_W - START_LEN);
                    end else begin
                        state_n   = ST_SEND_NAK;
                        tx_data_c = SH_W'(NAK_CODE) << (SH_W - NAK_LEN);
                    end
                end else if (cnt_q == CNT_W'(GRANT_TO - 1)) begin
                    state_n   = ST_IDLE;
                    timeout_c = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND_START: begin
                if (!arb_in) begin
                    state_n      = ST_IDLE;
                    tx_abort_c   = 1'b1;
                    lost_grant_c = 1'b1;
                end else if (tx_last_c) begin
                    state_n = ST_COM;
                end
            end
            ST_COM: begin
                if (!arb_in) begin
                    state_n      = ST_IDLE;
                    lost_grant_c = 1'b1;
                end else if (done) begin
                    state_n   = ST_SEND_END;
                    tx_load_c = 1'b1;
                    tx_data_c = SH_W'(END_CODE) << (SH_W - END_LEN);
                    tx_len_c  = LEN_W'(END_LEN);
                end
            end
            ST_SEND_END, ST_SEND_NAK: begin
                if (tx_last_c) begin
                    state_n = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!arb_in) begin
                    state_n = ST_IDLE;
                end else if (cnt_q == CNT_W'(REL_TO - 1)) begin
                    state_n   = ST_IDLE;
                    timeout_c = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
